// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the MIPS memory arbiter: FSM states,
// requester port indices and the word-alignment check.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic       PORT_I     = 1'b0;
  localparam logic       PORT_D     = 1'b1;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic misaligned(input logic [1:0] adr_lsb);
    return (adr_lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory-side bus of mem_arbiter.
// Handshake: a requester raises req with stable adr/we/wdata and holds it
// until it sees the one-cycle ack; ack carries rdata and err. req is only
// sampled while the arbiter is idle, so a req still high after ack is a new
// request. The memory side is a plain strobe bus; the memory writes on the
// clock edge while mem_mwr is high and returns read data combinationally.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          i_req;
  logic [AW-1:0] i_adr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          i_err;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_adr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          d_err;

  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_d_in;
  logic          mem_mrd;
  logic          mem_mwr;
  logic [DW-1:0] mem_d_out;

  logic          busy;

  // Arbiter side
  modport slave (
    input  i_req, i_adr, d_req, d_we, d_adr, d_wdata, mem_d_out,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
    output mem_adr, mem_d_in, mem_mrd, mem_mwr, busy
  );

  // Requesters and memory side
  modport master (
    output i_req, i_adr, d_req, d_we, d_adr, d_wdata, mem_d_out,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
    input  mem_adr, mem_d_in, mem_mrd, mem_mwr, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-request round-robin picker: on a tie the port that did not win last
// time is granted. Purely combinational, one-hot grant indexed by port.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last == PORT_I) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Sequencer and two-port round-robin arbiter for the shared MIPS memory.
// One transaction at a time: IDLE -> ACCESS (WAIT_CYCLES) -> DONE (ack).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus,
  output state_e         dbg_state
);

  localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          port_q, port_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          i_err_q, i_err_d;
  logic          d_err_q, d_err_d;
  logic [AW-1:0] mem_adr_q, mem_adr_d;
  logic [DW-1:0] mem_d_in_q, mem_d_in_d;
  logic          mem_mrd_q, mem_mrd_d;
  logic          mem_mwr_q, mem_mwr_d;
  logic          busy_q, busy_d;

  logic [1:0]    grant;
  logic          in_access;

  rr_arb2 u_rr_arb2 (
    .req   ({bus.d_req, bus.i_req}),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    port_d    = port_q;
    we_d      = we_q;
    err_d     = err_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          port_d = grant[PORT_D] ? PORT_D : PORT_I;
          last_d = port_d;
          if (port_d == PORT_D) begin
            adr_d   = bus.d_adr;
            we_d    = bus.d_we;
            wdata_d = bus.d_wdata;
          end else begin
            adr_d   = bus.i_adr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
          // A misaligned address never touches memory; it acks next cycle.
          err_d = misaligned(adr_d[1:0]);
          if (err_d) begin
            state_d = DONE;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (!we_q) begin
            if (port_q == PORT_D) d_rdata_d = bus.mem_d_out;
            else                  i_rdata_d = bus.mem_d_out;
          end
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next-state view so they line up
    // with the state they belong to.
    in_access  = (state_d == ACCESS);
    i_ack_d    = (state_d == DONE) && (port_d == PORT_I);
    d_ack_d    = (state_d == DONE) && (port_d == PORT_D);
    i_err_d    = i_ack_d && err_d;
    d_err_d    = d_ack_d && err_d;
    mem_adr_d  = in_access ? adr_d : '0;
    mem_d_in_d = in_access ? wdata_d : '0;
    mem_mrd_d  = in_access && !we_d;
    mem_mwr_d  = in_access && we_d && (cnt_d == '0);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= PORT_D;
      port_q     <= PORT_I;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      i_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
      mem_adr_q  <= '0;
      mem_d_in_q <= '0;
      mem_mrd_q  <= 1'b0;
      mem_mwr_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      port_q     <= port_d;
      we_q       <= we_d;
      err_q      <= err_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_ack_q    <= i_ack_d;
      d_ack_q    <= d_ack_d;
      i_err_q    <= i_err_d;
      d_err_q    <= d_err_d;
      mem_adr_q  <= mem_adr_d;
      mem_d_in_q <= mem_d_in_d;
      mem_mrd_q  <= mem_mrd_d;
      mem_mwr_q  <= mem_mwr_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.i_ack    = i_ack_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.i_err    = i_err_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_err    = d_err_q;
  assign bus.mem_adr  = mem_adr_q;
  assign bus.mem_d_in = mem_d_in_q;
  assign bus.mem_mrd  = mem_mrd_q;
  assign bus.mem_mwr  = mem_mwr_q;
  assign bus.busy     = busy_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and two-port arbiter for the shared byte-addressed data/instruction memory of the multi-cycle MIPS. Instruction fetch (read-only port I) and load/store (port D) request word accesses through a req/ack handshake. The block grants one requester at a time with round-robin priority and drives the memory's address, write-data and read/write strobes for a fixed number of access cycles. It returns a registered read word or an alignment error.

## Interface
Parameters:
- WAIT_CYCLES, 1, memory access cycles per transaction (≥1)
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  instruction-port request; held until i_ack
- i_adr  in  AW  instruction byte address; stable while i_req
- i_ack  out  1  one-cycle completion pulse, port I
- i_rdata  out  DW  fetched word; valid in i_ack cycle, held until next port-I ack
- i_err  out  1  misaligned address; valid with i_ack
- d_req  in  1  data-port request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_adr  in  AW  data byte address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle completion pulse, port D
- d_rdata  out  DW  loaded word; valid in d_ack cycle, held until next port-D ack
- d_err  out  1  misaligned address; valid with d_ack
- mem_adr  out  AW  memory address
- mem_d_in  out  DW  memory write data
- mem_mrd  out  1  memory read strobe
- mem_mwr  out  1  memory write strobe (memory writes on posedge when high)
- mem_d_out  in  DW  memory combinational read data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request → stay in IDLE.
  - Any request → pick a winner, latch its address, we (port I forces we = 0) and wdata, set `last` to the winner.
  - If the latched address has adr[1:0] ≠ 0, set err and go straight to DONE with no memory access. Otherwise load cnt = WAIT_CYCLES−1 and go to ACCESS.
- Arbitration: only one request → that port wins. Both requests → the port ≠ `last` wins. `last` resets to D, so port I wins the first tie after reset.
- ACCESS:
  - mem_adr and mem_d_in driven from the latched values.
  - mem_mrd = ~we throughout.
  - mem_mwr = we only when cnt == 0.
  - cnt ≠ 0 → decrement. cnt == 0 → capture mem_d_out into the granted port's rdata register (loads only) and go to DONE.
- DONE: assert the granted port's ack and err for exactly one cycle, then go to IDLE.
- Outside ACCESS: mem_adr, mem_d_in, mem_mrd and mem_mwr are all 0.
- Stores never modify rdata. On an errored access, rdata is unchanged.
- Reset values: state = IDLE, cnt = 0, `last` = D. All outputs 0, including i_rdata and d_rdata.

## Timing
- A request sampled at edge n produces ack high during cycle n+WAIT_CYCLES+1 (default: 2 cycles after sampling). A misaligned request acks in cycle n+1.
- Store: mem_mwr is high in exactly one cycle. The write commits at the edge ending the last ACCESS cycle.
- Handshake:
  - A requester deasserts req at the edge ending its ack cycle at the latest.
  - Req still high in the IDLE cycle after DONE counts as a new request.
  - Requests are sampled only in IDLE. Changing adr/wdata/we while granted has no effect.
- Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
- A losing requester keeps req high. It is granted on the next IDLE pass, so starvation is bounded to one transaction.
- Reset asserted mid-ACCESS: next state is IDLE, no mem_mwr in the following cycle, no ack issued, the aborted transaction is dropped.
- Req and rst high together: rst wins.

## Structure
- Package mem_arb_pkg: state enum {IDLE, ACCESS, DONE}, port constants PORT_I = 0 and PORT_D = 1, alignment mask constant.
- Sub-module rr_arb2: combinational 2-request round-robin picker. Inputs req[1:0] and last; outputs a one-hot grant. Instantiated once.
- Top level holds the FSM, cnt, latches, rdata registers and the memory drive.

## Test plan
- Single load, WAIT_CYCLES = 1: d_req, d_adr = 1000, memory word 0x0000_0007 → mem_mrd high 1 cycle, d_ack 2 cycles after sampling, d_rdata = 7, i_ack stays 0.
- Store then load: d_we = 1, d_adr = 2000, d_wdata = 0xFFFF_FFFB → mem_mwr high exactly 1 cycle. A subsequent load from 2000 returns 0xFFFF_FFFB (−5 signed).
- Tie after reset: i_req and d_req both high continuously → grant order I, D, I, D. Each ack occurs every 3 cycles and alternates ports.
- Misaligned access: d_adr = 1002 → d_ack and d_err one cycle after sampling, mem_mrd and mem_mwr never asserted, d_rdata unchanged.
- Reset mid-store: rst asserted during ACCESS with WAIT_CYCLES = 3 → mem_mwr never pulses, no ack, busy = 0 the cycle after, target word unchanged.
- WAIT_CYCLES = 4 fetch: i_adr = 0 → mem_mrd high 4 consecutive cycles, i_ack in cycle n+5, i_rdata = memory word 0.
